mem_stage: RTL and testbench

Memory-access pipeline stage: consumes the EX→MEM register bundle (branch flag, memory op, store data, control op, destination GPR, write-enable, exception code, ALU result), runs at most one word load/store on the CPU bus per instruction, and produces the MEM→WB register bundle. A small bus FSM with a wait-state timeout drives the bus and raises the pipeline stall request while an access is outstanding. Sits between the EX stage register and the WB/control unit.

---
 rtl/mem_stage_pkg.sv | 44 ++++
 rtl/mem_stage_bus_if.sv | 147 ++++++++++++++
 rtl/mem_stage.sv | 131 +++++++++++++
 tb/tb_mem_stage.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory-access stage: mem ops, exception codes,
// bus direction, bus FSM states and the MEM->WB register bundle.
package mem_stage_pkg;

  localparam int WORD_W = 32;
  localparam int ADDR_W = 30;
  localparam int REG_W  = 5;

  typedef enum logic [1:0] {
    MEM_OP_NOP = 2'd0,
    MEM_OP_LDW = 2'd1,
    MEM_OP_STW = 2'd2,
    MEM_OP_RSV = 2'd3
  } mem_op_e;

  localparam logic [2:0] ISA_EXP_NO_EXP     = 3'd0;
  localparam logic [2:0] ISA_EXP_MISS_ALIGN = 3'd4;
  localparam logic [2:0] ISA_EXP_BUS_ERR    = 3'd7;

  localparam logic BUS_READ  = 1'b1;
  localparam logic BUS_WRITE = 1'b0;

  typedef enum logic {
    BUS_IDLE   = 1'b0,
    BUS_ACCESS = 1'b1
  } bus_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic              en;
    logic              br_flag;
    logic [1:0]        ctrl_op;
    logic [REG_W-1:0]  dst_addr;
    logic              gpr_we_;
    logic [2:0]        exp_code;
    logic [WORD_W-1:0] out;
  } mem_reg_t;

  // Reserved op 3 falls through as a non-memory op.
  function automatic logic is_mem_op(input logic [1:0] op);
    return (op == MEM_OP_LDW) || (op == MEM_OP_STW);
  endfunction

endpackage

// File: rtl/mem_stage_bus_if.sv
// CPU bus master for one word access per instruction: IDLE/ACCESS FSM,
// wait-state timeout, registered bus outputs and a completion capture slot.
module mem_bus_if
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              acc_i,
  input  logic              is_load_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WORD_W-1:0] wr_data_i,
  input  logic [WORD_W-1:0] bus_rd_data_i,
  input  logic              bus_rdy_n_i,
  output logic              bus_as_n_o,
  output logic              bus_rw_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [WORD_W-1:0] bus_wr_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              bubble_o,
  output logic [WORD_W-1:0] rd_data_o,
  output bus_state_e        state_o
);

  localparam int              CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  bus_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              as_n_q, as_n_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              flush_pend_q, flush_pend_d;
  logic              cap_vld_q, cap_vld_d;
  logic              cap_err_q, cap_err_d;
  logic              cap_flush_q, cap_flush_d;
  logic [WORD_W-1:0] cap_data_q, cap_data_d;

  logic in_idle, in_access, at_last, done_now, start;

  assign in_idle   = (state_q == BUS_IDLE);
  assign in_access = (state_q == BUS_ACCESS);
  assign at_last   = (cnt_q == CNT_LAST);
  // Ready wins over the timeout on the last allowed cycle.
  assign done_now  = in_access & (~bus_rdy_n_i | at_last);
  // A captured result still owns the EX instruction, so it must not re-issue.
  assign start     = in_idle & acc_i & ~stall_i & ~flush_i & ~cap_vld_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    as_n_d       = as_n_q;
    rw_d         = rw_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    flush_pend_d = flush_pend_q;
    cap_vld_d    = cap_vld_q;
    cap_err_d    = cap_err_q;
    cap_flush_d  = cap_flush_q;
    cap_data_d   = cap_data_q;

    case (state_q)
      BUS_IDLE: begin
        flush_pend_d = 1'b0;
        if (start) begin
          state_d = BUS_ACCESS;
          cnt_d   = '0;
          as_n_d  = 1'b0;
          rw_d    = is_load_i ? BUS_READ : BUS_WRITE;
          addr_d  = addr_i;
          wdata_d = wr_data_i;
        end
      end
      BUS_ACCESS: begin
        if (done_now) begin
          state_d      = BUS_IDLE;
          as_n_d       = 1'b1;
          flush_pend_d = 1'b0;
        end else begin
          cnt_d        = cnt_q + CNT_W'(1);
          flush_pend_d = flush_pend_q | flush_i;
        end
      end
      default: state_d = BUS_IDLE;
    endcase

    // Completion under stall parks the result until the pipeline moves.
    if (done_now && stall_i) begin
      cap_vld_d   = 1'b1;
      cap_err_d   = bus_rdy_n_i;
      cap_data_d  = bus_rd_data_i;
      cap_flush_d = flush_pend_q | flush_i;
    end else if (cap_vld_q) begin
      cap_flush_d = cap_flush_q | flush_i;
      if (!stall_i) begin
        cap_vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= BUS_IDLE;
      cnt_q        <= '0;
      as_n_q       <= 1'b1;
      rw_q         <= BUS_READ;
      addr_q       <= '0;
      wdata_q      <= '0;
      flush_pend_q <= 1'b0;
      cap_vld_q    <= 1'b0;
      cap_err_q    <= 1'b0;
      cap_flush_q  <= 1'b0;
      cap_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      as_n_q       <= as_n_d;
      rw_q         <= rw_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      flush_pend_q <= flush_pend_d;
      cap_vld_q    <= cap_vld_d;
      cap_err_q    <= cap_err_d;
      cap_flush_q  <= cap_flush_d;
      cap_data_q   <= cap_data_d;
    end
  end

  assign busy_o        = (in_idle & acc_i & ~flush_i & ~cap_vld_q) |
                         (in_access & bus_rdy_n_i & ~at_last);
  assign done_o        = done_now | cap_vld_q;
  assign err_o         = cap_vld_q ? cap_err_q : (done_now & bus_rdy_n_i);
  assign rd_data_o     = cap_vld_q ? cap_data_q : bus_rd_data_i;
  assign bubble_o      = cap_vld_q ? cap_flush_q : flush_pend_q;
  assign bus_as_n_o    = as_n_q;
  assign bus_rw_o      = rw_q;
  assign bus_addr_o    = addr_q;
  assign bus_wr_data_o = wdata_q;
  assign state_o       = state_q;

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: alignment check, access request, result mux and the
// MEM->WB register. Bus sequencing lives in mem_bus_if.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  output logic        busy,
  input  logic [29:0] ex_pc,
  input  logic        ex_en,
  input  logic        ex_br_flag,
  input  logic [1:0]  ex_mem_op,
  input  logic [31:0] ex_mem_wr_data,
  input  logic [1:0]  ex_ctrl_op,
  input  logic [4:0]  ex_dst_addr,
  input  logic        ex_gpr_we_,
  input  logic [2:0]  ex_exp_code,
  input  logic [31:0] ex_out,
  input  logic [31:0] bus_rd_data,
  input  logic        bus_rdy_,
  output logic        bus_as_,
  output logic        bus_rw,
  output logic [29:0] bus_addr,
  output logic [31:0] bus_wr_data,
  output logic [29:0] mem_pc,
  output logic        mem_en,
  output logic        mem_br_flag,
  output logic [1:0]  mem_ctrl_op,
  output logic [4:0]  mem_dst_addr,
  output logic        mem_gpr_we_,
  output logic [2:0]  mem_exp_code,
  output logic [31:0] mem_out
);

  logic              mem_req, aligned, no_exp, acc, miss_align, mem_update;
  logic              bus_done, bus_err, bus_bubble;
  logic [WORD_W-1:0] bus_rd;
  bus_state_e        bus_state;
  mem_reg_t          mem_q, mem_d;

  // Valid handshake: an access is requested while acc is high and the stage
  // advances only on a cycle with !stall & !busy; EX must hold its fields
  // until that cycle.
  assign mem_req    = is_mem_op(ex_mem_op);
  assign aligned    = (ex_out[1:0] == 2'b00);
  assign no_exp     = (ex_exp_code == ISA_EXP_NO_EXP);
  assign acc        = ex_en & no_exp & mem_req & aligned;
  assign miss_align = mem_req & ~aligned & no_exp;
  assign mem_update = ~stall & ~busy;

  mem_bus_if #(
    .TIMEOUT(TIMEOUT)
  ) u_bus_if (
    .clk          (clk),
    .reset        (reset),
    .stall_i      (stall),
    .flush_i      (flush),
    .acc_i        (acc),
    .is_load_i    (ex_mem_op == MEM_OP_LDW),
    .addr_i       (ex_out[31:2]),
    .wr_data_i    (ex_mem_wr_data),
    .bus_rd_data_i(bus_rd_data),
    .bus_rdy_n_i  (bus_rdy_),
    .bus_as_n_o   (bus_as_),
    .bus_rw_o     (bus_rw),
    .bus_addr_o   (bus_addr),
    .bus_wr_data_o(bus_wr_data),
    .busy_o       (busy),
    .done_o       (bus_done),
    .err_o        (bus_err),
    .bubble_o     (bus_bubble),
    .rd_data_o    (bus_rd),
    .state_o      (bus_state)
  );

  always_comb begin
    mem_d.pc       = ex_pc;
    mem_d.en       = ex_en;
    mem_d.br_flag  = ex_br_flag;
    mem_d.ctrl_op  = ex_ctrl_op;
    mem_d.dst_addr = ex_dst_addr;
    mem_d.gpr_we_  = ex_gpr_we_;
    mem_d.exp_code = ex_exp_code;
    mem_d.out      = ex_out;

    if (bus_done) begin
      if (bus_err) begin
        mem_d.gpr_we_  = 1'b1;
        mem_d.exp_code = ISA_EXP_BUS_ERR;
        mem_d.out      = '0;
      end else if (ex_mem_op == MEM_OP_LDW) begin
        mem_d.out = bus_rd;
      end
    end else if (miss_align) begin
      mem_d.gpr_we_  = 1'b1;
      mem_d.exp_code = ISA_EXP_MISS_ALIGN;
    end

    // A flushed instruction still finishes its bus cycle but retires as a bubble.
    if (flush || (bus_done && bus_bubble)) begin
      mem_d         = '0;
      mem_d.gpr_we_ = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q         <= '0;
      mem_q.gpr_we_ <= 1'b1;
    end else if (mem_update) begin
      mem_q <= mem_d;
    end
  end

  assign mem_pc       = mem_q.pc;
  assign mem_en       = mem_q.en;
  assign mem_br_flag  = mem_q.br_flag;
  assign mem_ctrl_op  = mem_q.ctrl_op;
  assign mem_dst_addr = mem_q.dst_addr;
  assign mem_gpr_we_  = mem_q.gpr_we_;
  assign mem_exp_code = mem_q.exp_code;
  assign mem_out      = mem_q.out;

  as_tracks_state: assert property (@(posedge clk) disable iff (reset)
    (bus_state == BUS_ACCESS) == ~bus_as_);

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed cases, reset mid-access, then randomized
// instructions with random stall/flush and a wait-state bus slave.
module tb_mem_stage;

  localparam int TIMEOUT = 16;
  localparam int BW      = 75;
  localparam logic [BW-1:0] RESET_BUNDLE = {30'd0, 1'b0, 1'b0, 2'd0, 5'd0, 1'b1, 3'd0, 32'd0};
  localparam logic [1:0] OP_NOP = 2'd0, OP_LDW = 2'd1, OP_STW = 2'd2;

  logic        clk = 1'b0;
  logic        reset, stall, flush, busy;
  logic [29:0] ex_pc;
  logic        ex_en, ex_br_flag, ex_gpr_we_;
  logic [1:0]  ex_mem_op, ex_ctrl_op;
  logic [31:0] ex_mem_wr_data, ex_out;
  logic [4:0]  ex_dst_addr;
  logic [2:0]  ex_exp_code;
  logic [31:0] bus_rd_data;
  logic        bus_rdy_, bus_as_, bus_rw;
  logic [29:0] bus_addr;
  logic [31:0] bus_wr_data;
  logic [29:0] mem_pc;
  logic        mem_en, mem_br_flag, mem_gpr_we_;
  logic [1:0]  mem_ctrl_op;
  logic [4:0]  mem_dst_addr;
  logic [2:0]  mem_exp_code;
  logic [31:0] mem_out;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .busy(busy),
    .ex_pc(ex_pc), .ex_en(ex_en), .ex_br_flag(ex_br_flag), .ex_mem_op(ex_mem_op),
    .ex_mem_wr_data(ex_mem_wr_data), .ex_ctrl_op(ex_ctrl_op), .ex_dst_addr(ex_dst_addr),
    .ex_gpr_we_(ex_gpr_we_), .ex_exp_code(ex_exp_code), .ex_out(ex_out),
    .bus_rd_data(bus_rd_data), .bus_rdy_(bus_rdy_), .bus_as_(bus_as_), .bus_rw(bus_rw),
    .bus_addr(bus_addr), .bus_wr_data(bus_wr_data),
    .mem_pc(mem_pc), .mem_en(mem_en), .mem_br_flag(mem_br_flag), .mem_ctrl_op(mem_ctrl_op),
    .mem_dst_addr(mem_dst_addr), .mem_gpr_we_(mem_gpr_we_), .mem_exp_code(mem_exp_code),
    .mem_out(mem_out)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] mem_exp;

  // Current instruction and its progress through the stage.
  logic [29:0] i_pc;
  logic        i_en, i_br, i_we_;
  logic [1:0]  i_op, i_ctrl;
  logic [31:0] i_wd, i_out;
  logic [4:0]  i_dst;
  logic [2:0]  i_exp;
  int          i_wait;
  bit          flushed, err_cap;
  logic [31:0] rd_cap;
  int          phase, k;   // phase: 0 waiting, 1 bus cycle running, 2 bus done

  int   stall_pct = 0, flush_pct = 0, flush_at = -1;
  bit   rd_fixed_en = 0;
  logic [31:0] rd_fixed;

  task automatic check_eq(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] dut_bundle();
    return {mem_pc, mem_en, mem_br_flag, mem_ctrl_op, mem_dst_addr, mem_gpr_we_, mem_exp_code, mem_out};
  endfunction

  function automatic bit f_acc();
    return i_en && i_exp == 3'd0 && (i_op == OP_LDW || i_op == OP_STW) && i_out[1:0] == 2'd0;
  endfunction

  function automatic logic [BW-1:0] expected_bundle();
    logic        we_n;
    logic [2:0]  exc;
    logic [31:0] res;
    if (flushed) return RESET_BUNDLE;
    we_n = i_we_;
    exc  = i_exp;
    res  = i_out;
    if (f_acc()) begin
      if (err_cap) begin
        we_n = 1'b1;
        exc  = 3'd7;
        res  = 32'd0;
      end else if (i_op == OP_LDW) begin
        res = rd_cap;
      end
    end else if (i_exp == 3'd0 && (i_op == OP_LDW || i_op == OP_STW) && i_out[1:0] != 2'd0) begin
      we_n = 1'b1;
      exc  = 3'd4;
    end
    return {i_pc, i_en, i_br, i_ctrl, i_dst, we_n, exc, res};
  endfunction

  task automatic set_instr(input logic [1:0] op, input logic [31:0] out, input logic [31:0] wd,
                           input logic [2:0] exc, input logic we_n, input int w);
    i_pc   = 30'($urandom());
    i_en   = 1'b1;
    i_br   = 1'($urandom_range(1));
    i_ctrl = 2'($urandom_range(3));
    i_dst  = 5'($urandom_range(31));
    i_op   = op;
    i_out  = out;
    i_wd   = wd;
    i_exp  = exc;
    i_we_  = we_n;
    i_wait = w;
  endtask

  task automatic random_instr();
    logic [31:0] o;
    o = $urandom();
    if ($urandom_range(4) != 0) o[1:0] = 2'b00;
    set_instr(2'($urandom_range(3)), o, $urandom(),
              ($urandom_range(9) == 0) ? 3'($urandom_range(1, 7)) : 3'd0,
              1'($urandom_range(1)),
              ($urandom_range(9) == 0) ? $urandom_range(TIMEOUT + 4) : $urandom_range(3));
    i_en = ($urandom_range(9) != 0);
  endtask

  // Presents the current instruction at a negedge and runs it to acceptance.
  task automatic run_instr();
    bit accepted = 0;
    bit completes, eb, do_accept;
    int cyc = 0;
    phase = 0; k = 0; flushed = 0; err_cap = 0;
    ex_pc = i_pc; ex_en = i_en; ex_br_flag = i_br; ex_mem_op = i_op; ex_mem_wr_data = i_wd;
    ex_ctrl_op = i_ctrl; ex_dst_addr = i_dst; ex_gpr_we_ = i_we_; ex_exp_code = i_exp; ex_out = i_out;
    while (!accepted) begin
      if (cyc >= 400) begin
        n_tests++; n_fail++;
        $display("FAIL instr_budget: got no acceptance after %0d cycles, required acceptance", cyc);
        return;
      end
      stall = ($urandom_range(99) < stall_pct);
      flush = (!stall && $urandom_range(99) < flush_pct) || (cyc == flush_at);
      if (flush) flushed = 1;
      bus_rdy_    = (phase == 1) ? ((k == i_wait) ? 1'b0 : 1'b1) : 1'($urandom_range(1));
      bus_rd_data = rd_fixed_en ? rd_fixed : $urandom();
      completes = (phase == 1) && (bus_rdy_ == 1'b0 || k == TIMEOUT - 1);
      case (phase)
        0:       eb = f_acc() && !flush;
        1:       eb = !completes;
        default: eb = 0;
      endcase
      #1;
      check_eq("busy", busy, eb);
      do_accept = 0;
      if (phase == 0) begin
        if (f_acc() && !stall && !flush) begin
          phase = 1; k = 0;
        end else if (!stall && !eb) begin
          do_accept = 1;
        end
      end else if (phase == 1) begin
        if (completes) begin
          err_cap = bus_rdy_;
          rd_cap  = bus_rd_data;
          phase   = 2;
          if (!stall) do_accept = 1;
        end else begin
          k++;
        end
      end else if (!stall) begin
        do_accept = 1;
      end
      if (do_accept) begin
        exp_q.push_back(expected_bundle());
        accepted = 1;
      end
      @(posedge clk);
      @(negedge clk);
      if (exp_q.size() > 0) mem_exp = exp_q.pop_front();
      check_eq("mem_reg", dut_bundle(), mem_exp);
      check_eq("bus_as_", bus_as_, (phase == 1) ? 1'b0 : 1'b1);
      if (phase == 1) begin
        check_eq("bus_addr", bus_addr, i_out[31:2]);
        check_eq("bus_rw", bus_rw, (i_op == OP_LDW) ? 1'b1 : 1'b0);
        check_eq("bus_wr_data", bus_wr_data, i_wd);
      end
      cyc++;
    end
    flush = 0;
    stall = 0;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_mem"}, dut_bundle(), RESET_BUNDLE);
    check_eq({tag, "_as"}, bus_as_, 1'b1);
    check_eq({tag, "_rw"}, bus_rw, 1'b1);
    check_eq({tag, "_addr"}, bus_addr, 30'd0);
    check_eq({tag, "_wdata"}, bus_wr_data, 32'd0);
    check_eq({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    reset = 1; stall = 0; flush = 0; bus_rdy_ = 1; bus_rd_data = 0;
    ex_pc = 0; ex_en = 0; ex_br_flag = 0; ex_mem_op = 0; ex_mem_wr_data = 0;
    ex_ctrl_op = 0; ex_dst_addr = 0; ex_gpr_we_ = 1; ex_exp_code = 0; ex_out = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 0;
    check_reset_state("reset");
    mem_exp = RESET_BUNDLE;

    // Directed cases
    set_instr(OP_NOP, 32'h1234_5678, 32'h0, 3'd0, 1'b0, 0); run_instr();
    rd_fixed_en = 1; rd_fixed = 32'hDEAD_BEEF;
    set_instr(OP_LDW, 32'h0000_0100, 32'h0, 3'd0, 1'b0, 0); run_instr();
    rd_fixed_en = 0;
    set_instr(OP_STW, 32'h0000_0104, 32'hA5A5_A5A5, 3'd0, 1'b0, 3); run_instr();
    set_instr(OP_LDW, 32'h0000_0102, 32'h0, 3'd0, 1'b0, 0); run_instr();
    set_instr(OP_LDW, 32'h0000_0200, 32'h0, 3'd0, 1'b0, 100); run_instr();
    set_instr(OP_LDW, 32'h0000_0300, 32'h0, 3'd0, 1'b0, TIMEOUT - 1); run_instr();
    set_instr(OP_LDW, 32'h0000_0304, 32'h0, 3'd0, 1'b0, 0); run_instr();
    flush_at = 3;
    set_instr(OP_STW, 32'h0000_0400, 32'h1357_9BDF, 3'd0, 1'b0, 5); run_instr();
    flush_at = -1;
    set_instr(OP_LDW, 32'h0000_0500, 32'h0, 3'd2, 1'b0, 0); run_instr();
    set_instr(3'd3, 32'h0000_0601, 32'h0, 3'd0, 1'b0, 0); run_instr();

    // Reset in the middle of a waited load
    set_instr(OP_LDW, 32'h0000_0700, 32'h0, 3'd0, 1'b0, 100);
    ex_pc = i_pc; ex_en = 1; ex_mem_op = OP_LDW; ex_out = i_out; ex_exp_code = 0;
    bus_rdy_ = 1;
    @(posedge clk); @(negedge clk);
    check_eq("rst_pre_as", bus_as_, 1'b0);
    @(posedge clk); @(negedge clk);
    reset = 1; ex_en = 0; bus_rdy_ = 0;
    @(posedge clk); @(negedge clk);
    check_reset_state("mid_reset");
    reset = 0; bus_rdy_ = 1;
    mem_exp = RESET_BUNDLE;
    set_instr(OP_NOP, 32'hCAFE_F00D, 32'h0, 3'd0, 1'b0, 0); run_instr();

    // Randomized traffic with stalls and flushes
    stall_pct = 20; flush_pct = 5;
    for (int n = 0; n < 300; n++) begin
      random_instr();
      run_instr();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
